vend_dispense_ctrl: RTL and testbench

VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

---
 rtl/vend_dispense_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: validates payment, pulses the item motor once
// per item (held until the motor acknowledges), then refunds change as a
// greedy sequence of $10/$5/$2/$1 coin-ejector pulses separated by idle gaps.
module vend_dispense_ctrl #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] quantity,
  input  logic [7:0] price_total,
  input  logic [7:0] paid,
  input  logic       item_done,
  output logic       busy,
  output logic       item_motor,
  output logic       coin10,
  output logic       coin5,
  output logic       coin2,
  output logic       coin1,
  output logic [3:0] items_left,
  output logic [7:0] change_left,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_VGAP,
    S_CHANGE,
    S_CPULSE,
    S_CGAP,
    S_FIN
  } state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [3:0] qty_q;
  logic [7:0] price_q;
  logic [7:0] paid_q;
  logic       busy_q;
  logic       motor_q;
  logic [3:0] coin_q;      // one-hot {10, 5, 2, 1}
  logic [3:0] items_q;
  logic [7:0] change_q;
  logic       done_q;
  logic       error_q;     // latched reject flag, doubles as the error strobe in FIN

  logic [3:0] coin_sel_d;
  logic [7:0] coin_val;

  // Largest coin not exceeding the remaining change.
  always_comb begin
    coin_sel_d = 4'b0001;
    if (change_q >= 8'd10)     coin_sel_d = 4'b1000;
    else if (change_q >= 8'd5) coin_sel_d = 4'b0100;
    else if (change_q >= 8'd2) coin_sel_d = 4'b0010;
  end

  // Dollar value of the coin currently being ejected.
  always_comb begin
    coin_val = '0;
    case (coin_q)
      4'b1000: coin_val = 8'd10;
      4'b0100: coin_val = 8'd5;
      4'b0010: coin_val = 8'd2;
      4'b0001: coin_val = 8'd1;
      default: coin_val = '0;
    endcase
  end

  // Main sequencer; every output is a register updated on state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      qty_q    <= '0;
      price_q  <= '0;
      paid_q   <= '0;
      busy_q   <= 1'b0;
      motor_q  <= 1'b0;
      coin_q   <= '0;
      items_q  <= '0;
      change_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            qty_q   <= quantity;
            price_q <= price_total;
            paid_q  <= paid;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          cnt_q <= '0;
          if (paid_q < price_q) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            change_q <= paid_q - price_q;
            items_q  <= qty_q;
            if (qty_q != 4'd0) begin
              motor_q <= 1'b1;
              state_q <= S_VEND;
            end else begin
              state_q <= S_CHANGE;
            end
          end
        end
        S_VEND: begin
          // The counter saturates at the minimum width; only then is an ack honoured.
          if (cnt_q != PULSE_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else if (item_done) begin
            items_q <= items_q - 4'd1;
            motor_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_VGAP;
          end
        end
        S_VGAP: begin
          if (cnt_q != GAP_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            if (items_q != 4'd0) begin
              motor_q <= 1'b1;
              state_q <= S_VEND;
            end else begin
              state_q <= S_CHANGE;
            end
          end
        end
        S_CHANGE: begin
          cnt_q <= '0;
          if (change_q == 8'd0) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            coin_q  <= coin_sel_d;
            state_q <= S_CPULSE;
          end
        end
        S_CPULSE: begin
          if (cnt_q != PULSE_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            change_q <= change_q - coin_val;
            coin_q   <= '0;
            cnt_q    <= '0;
            state_q  <= S_CGAP;
          end
        end
        S_CGAP: begin
          if (cnt_q != GAP_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q   <= '0;
            state_q <= S_CHANGE;
          end
        end
        S_FIN: begin
          busy_q   <= 1'b0;
          error_q  <= 1'b0;
          items_q  <= '0;
          change_q <= '0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign item_motor  = motor_q;
  assign coin10      = coin_q[3];
  assign coin5       = coin_q[2];
  assign coin2       = coin_q[1];
  assign coin1       = coin_q[0];
  assign items_left  = items_q;
  assign change_left = change_q;
  assign done        = done_q;
  assign error       = error_q & done_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: transaction-level model (greedy change list,
// per-item motor widths, total latency arithmetic) versus observed pulses.
`timescale 1ns/1ps
module tb_vend_dispense_ctrl;

  localparam int P = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] quantity;
  logic [7:0] price_total;
  logic [7:0] paid;
  logic       item_done;
  logic       busy;
  logic       item_motor;
  logic       coin10;
  logic       coin5;
  logic       coin2;
  logic       coin1;
  logic [3:0] items_left;
  logic [7:0] change_left;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_dispense_ctrl #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .quantity   (quantity),
    .price_total(price_total),
    .paid       (paid),
    .item_done  (item_done),
    .busy       (busy),
    .item_motor (item_motor),
    .coin10     (coin10),
    .coin5      (coin5),
    .coin2      (coin2),
    .coin1      (coin1),
    .items_left (items_left),
    .change_left(change_left),
    .done       (done),
    .error      (error)
  );

  // One complete request; called at a negedge with the DUT idle, returns at a negedge idle.
  task automatic run_vend(input int q, input int pr, input int pd, input int fixed_d,
                          input bit noise, input string tag);
    int  d[$];
    int  exp_coins[$];
    int  denoms[4];
    int  rem, exp_done, exp_motors, w;
    bit  exp_err;
    int  cyc, done_cyc, items_at_done, change_at_done;
    bit  seen_done, err_obs;
    int  mrun, crun, cval, mi;
    int  mw[$];
    int  m_items[$];
    int  cw[$];
    int  cv[$];
    int  c_change[$];
    int  excl, busy_low, stray_err;

    denoms = '{10, 5, 2, 1};
    exp_err = (pd < pr);
    for (int i = 0; i < q; i++)
      d.push_back(fixed_d >= 0 ? fixed_d : int'($urandom_range(0, P + 3)));
    if (!exp_err) begin
      rem = pd - pr;
      while (rem > 0) begin
        for (int k = 0; k < 4; k++) begin
          if (denoms[k] <= rem) begin
            exp_coins.push_back(denoms[k]);
            rem -= denoms[k];
            break;
          end
        end
      end
    end
    exp_motors = exp_err ? 0 : q;
    if (exp_err) begin
      exp_done = 2;
    end else begin
      exp_done = 3 + exp_coins.size() * (1 + P + G);
      for (int i = 0; i < q; i++) begin
        w = (d[i] + 1 > P) ? d[i] + 1 : P;
        exp_done += w + G;
      end
    end

    start       = 1'b1;
    quantity    = 4'(q);
    price_total = 8'(pr);
    paid        = 8'(pd);
    item_done   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    cyc = 0; seen_done = 0; mrun = 0; crun = 0; mi = 0;
    excl = 0; busy_low = 0; stray_err = 0;
    done_cyc = 0; err_obs = 0; items_at_done = 0; change_at_done = 0;

    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      quantity    = 4'($urandom);
      price_total = 8'($urandom);
      paid        = 8'($urandom);
      if (int'(item_motor) + int'(coin10) + int'(coin5) + int'(coin2) + int'(coin1) > 1) excl++;
      if (!busy) busy_low++;
      if (error && !done) stray_err++;
      if (item_motor) begin
        if (mrun == 0) m_items.push_back(int'(items_left));
        mrun++;
        item_done = (mi < d.size()) ? (mrun - 1 >= d[mi]) : 1'b1;
      end else begin
        if (mrun > 0) begin
          mw.push_back(mrun);
          mrun = 0;
          mi++;
        end
        item_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      cval = coin10 ? 10 : coin5 ? 5 : coin2 ? 2 : coin1 ? 1 : 0;
      if (cval != 0) begin
        if (crun == 0) begin
          cv.push_back(cval);
          c_change.push_back(int'(change_left));
        end
        crun++;
      end else if (crun > 0) begin
        cw.push_back(crun);
        crun = 0;
      end
      if (done) begin
        seen_done      = 1;
        done_cyc       = cyc;
        err_obs        = error;
        items_at_done  = int'(items_left);
        change_at_done = int'(change_left);
      end
    end

    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, required done by cycle %0d", tag, cyc, exp_done);
    end else begin
      checks++;
      if (done_cyc != exp_done) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d, expected %0d", tag, done_cyc, exp_done);
      end
      checks++;
      if (err_obs !== exp_err) begin
        errors++;
        $display("FAIL %s error_flag: got %0d, expected %0d", tag, err_obs, exp_err);
      end
      checks++;
      if (items_at_done != 0 || change_at_done != 0) begin
        errors++;
        $display("FAIL %s counts_at_done: items_left=%0d change_left=%0d, expected 0/0",
                 tag, items_at_done, change_at_done);
      end
    end

    checks++;
    if (mw.size() != exp_motors) begin
      errors++;
      $display("FAIL %s motor_pulses: got %0d, expected %0d", tag, mw.size(), exp_motors);
    end
    for (int i = 0; i < mw.size() && i < exp_motors; i++) begin
      w = (d[i] + 1 > P) ? d[i] + 1 : P;
      checks++;
      if (mw[i] != w || m_items[i] != q - i) begin
        errors++;
        $display("FAIL %s motor[%0d]: width=%0d items_left=%0d, expected width=%0d items_left=%0d",
                 tag, i, mw[i], m_items[i], w, q - i);
      end
    end

    checks++;
    if (cv.size() != exp_coins.size()) begin
      errors++;
      $display("FAIL %s coin_count: got %0d, expected %0d", tag, cv.size(), exp_coins.size());
    end
    rem = exp_err ? 0 : pd - pr;
    for (int i = 0; i < cv.size() && i < exp_coins.size(); i++) begin
      checks++;
      if (cv[i] != exp_coins[i] || i >= cw.size() || c_change[i] != rem) begin
        errors++;
        $display("FAIL %s coin[%0d]: value=%0d change_left=%0d, expected value=%0d change_left=%0d",
                 tag, i, cv[i], c_change[i], exp_coins[i], rem);
      end else if (cw[i] != P) begin
        errors++;
        $display("FAIL %s coin_width[%0d]: got %0d, expected %0d", tag, i, cw[i], P);
      end
      rem -= exp_coins[i];
    end

    checks++;
    if (excl != 0 || busy_low != 0 || stray_err != 0) begin
      errors++;
      $display("FAIL %s invariants: overlap=%0d busy_low=%0d stray_error=%0d, expected 0/0/0",
               tag, excl, busy_low, stray_err);
    end

    // Back in IDLE; any start seen during FIN must not have been queued.
    @(negedge clk);
    start     = 1'b0;
    item_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || items_left !== 4'd0 || change_left !== 8'd0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%0b done=%0b error=%0b items=%0d change=%0d, expected all 0",
               tag, busy, done, error, items_left, change_left);
    end
    @(negedge clk);
    item_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s no_queued_start: busy=%0b, expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; item_done = 1'b0;
    quantity = '0; price_total = '0; paid = '0;
    #2;
    checks++;
    if ({busy, item_motor, coin10, coin5, coin2, coin1, done, error} !== 8'b0 ||
        items_left !== 4'd0 || change_left !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: flags=%b items=%0d change=%0d, expected all 0",
               {busy, item_motor, coin10, coin5, coin2, coin1, done, error}, items_left, change_left);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_directed();
    run_vend(1, 6, 10, 6, 1'b0, "req038");
    run_vend(2, 20, 37, -1, 1'b0, "req039");
    run_vend(1, 6, 5, -1, 1'b0, "req040");
    run_vend(0, 0, 8, -1, 1'b0, "req041");
  endtask

  task automatic test_boundaries();
    run_vend(15, 0, 255, 0, 1'b0, "max_qty_max_change");
    run_vend(3, 50, 50, -1, 1'b0, "exact_pay");
    run_vend(2, 50, 49, -1, 1'b0, "short_by_one");
    run_vend(0, 0, 0, -1, 1'b0, "empty_request");
    run_vend(1, 0, 1, 20, 1'b0, "slow_ack");
  endtask

  task automatic test_noise();
    run_vend(2, 7, 30, -1, 1'b1, "noise_a");
    run_vend(3, 1, 19, 1, 1'b1, "noise_b");
  endtask

  task automatic test_reset_midpulse();
    int run;
    int guard;
    start = 1'b1; quantity = 4'd0; price_total = 8'd0; paid = 8'd10; item_done = 1'b0;
    run = 0; guard = 0;
    while (run < 2 && guard < 100) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      run = coin10 ? run + 1 : 0;
    end
    checks++;
    if (run < 2) begin
      errors++;
      $display("FAIL midpulse_setup: coin10 run=%0d after %0d cycles, expected 2", run, guard);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (coin10 !== 1'b0 || busy !== 1'b0 || change_left !== 8'd0 || items_left !== 4'd0 ||
        item_motor !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midpulse_async_reset: coin10=%0b busy=%0b change=%0d items=%0d, expected 0",
               coin10, busy, change_left, items_left);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || coin10 !== 1'b0 || change_left !== 8'd0) begin
      errors++;
      $display("FAIL no_resume: busy=%0b coin10=%0b change=%0d, expected 0", busy, coin10, change_left);
    end
    run_vend(1, 1, 1, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int q, pr, pd;
    for (int n = 0; n < 30; n++) begin
      q  = $urandom_range(0, 5);
      pr = $urandom_range(0, 60);
      if (pr > 0 && $urandom_range(0, 4) == 0) pd = $urandom_range(0, pr - 1);
      else pd = (pr + $urandom_range(0, 45) > 255) ? 255 : pr + $urandom_range(0, 45);
      run_vend(q, pr, pd, -1, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    run_vend(1, 3, 4, 0, 1'b1, "b2b_a");
    run_vend(0, 2, 14, -1, 1'b1, "b2b_b");
    run_vend(2, 9, 3, -1, 1'b1, "b2b_c");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_noise();
    test_reset_midpulse();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
